fifo_ptr_ctrl: RTL and testbench

Parametrised pointer and status controller for the single-clock FIFO, replacing the free-running write-address counter. It generates the write and read addresses for a MEMORY_DEPTH-entry buffer, with correct wrap-around for any depth including non-powers-of-two. It also produces registered full/empty/almost flags, an occupancy count and overflow/underflow error pulses. It sits between the FIFO's client handshake and the dual-port storage array.

---
 rtl/fifo_ptr_ctrl_pkg.sv | 22 ++
 rtl/fifo_ptr_ctrl_if.sv | 37 +++
 rtl/fifo_ptr_ctrl_wrap_ptr.sv | 53 +++++
 rtl/fifo_ptr_ctrl.sv | 125 ++++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared defaults and helper types for the FIFO pointer/status controller.
package fifo_ptr_ctrl_pkg;

  // Default geometry used by all FIFO blocks
  localparam int FIFO_DEPTH_DEF        = 4;
  localparam int FIFO_AW_DEF           = 2;
  localparam int FIFO_ALMOST_FULL_DEF  = FIFO_DEPTH_DEF - 1;
  localparam int FIFO_ALMOST_EMPTY_DEF = 1;

  // Per-cycle occupancy operation, encoded as {push, pop}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Client handshake and storage-side address/status bundle for fifo_ptr_ctrl.
interface fifo_ptr_ctrl_if
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int AW = FIFO_AW_DEF
);

  logic          flush;
  logic          wr_req;
  logic          rd_req;
  logic          w_en;
  logic          r_en;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  // Client side: issues requests, observes strobes, addresses and status
  modport master (
    output flush, wr_req, rd_req,
    input  w_en, r_en, w_addr, r_addr, count,
    input  full, empty, almost_full, almost_empty, overflow, underflow
  );

  // Controller side
  modport slave (
    input  flush, wr_req, rd_req,
    output w_en, r_en, w_addr, r_addr, count,
    output full, empty, almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr_ctrl_wrap_ptr.sv
// Modulo-DEPTH address counter with a wrap bit that toggles each time the
// address returns to zero. Works for non-power-of-two depths.
module wrap_ptr_counter
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = FIFO_AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] addr,
  output logic          wrap
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [AW-1:0] addr_q, addr_d;
  logic          wrap_q, wrap_d;

  // Next pointer: clear wins, otherwise step and fold back at the last entry
  always_comb begin
    addr_d = addr_q;
    wrap_d = wrap_q;
    if (clr) begin
      addr_d = '0;
      wrap_d = 1'b0;
    end else if (inc) begin
      if (addr_q == LAST_ADDR) begin
        addr_d = '0;
        wrap_d = ~wrap_q;
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wrap_q <= wrap_d;
    end
  end

  assign addr = addr_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and status controller for the single-clock FIFO. Accepts client
// requests combinationally and keeps pointers, occupancy, status flags and
// error pulses in registers updated one cycle after acceptance.
module fifo_ptr_ctrl
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int MEMORY_DEPTH       = FIFO_DEPTH_DEF,
  parameter int FIFO_ADDRESS_SIZE  = FIFO_AW_DEF,
  parameter int ALMOST_FULL_LEVEL  = MEMORY_DEPTH - 1,
  parameter int ALMOST_EMPTY_LEVEL = FIFO_ALMOST_EMPTY_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  fifo_ptr_ctrl_if.slave bus
);

  localparam int             CW      = FIFO_ADDRESS_SIZE + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(MEMORY_DEPTH);
  localparam logic           AE_RST  = (ALMOST_EMPTY_LEVEL >= 0);

  logic                         w_en, r_en;
  logic [FIFO_ADDRESS_SIZE-1:0] wr_addr, rd_addr;
  logic                         wr_wrap, rd_wrap;

  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  // Acceptance: full does not block a write when a read frees a slot in the
  // same cycle; empty always blocks a read (no write-to-read bypass).
  assign r_en = bus.rd_req & ~empty_q & ~bus.flush;
  assign w_en = bus.wr_req & (~full_q | bus.rd_req) & ~bus.flush;

  wrap_ptr_counter #(
    .DEPTH (MEMORY_DEPTH),
    .AW    (FIFO_ADDRESS_SIZE)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.flush),
    .inc   (w_en),
    .addr  (wr_addr),
    .wrap  (wr_wrap)
  );

  wrap_ptr_counter #(
    .DEPTH (MEMORY_DEPTH),
    .AW    (FIFO_ADDRESS_SIZE)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.flush),
    .inc   (r_en),
    .addr  (rd_addr),
    .wrap  (rd_wrap)
  );

  // Occupancy next state; acceptance logic already keeps it in 0..DEPTH
  always_comb begin
    count_d = count_q;
    if (bus.flush) begin
      count_d = '0;
    end else begin
      case (fifo_op(w_en, r_en))
        OP_PUSH: count_d = count_q + CW'(1);
        OP_POP:  count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Flags derived from next-state count so they never lag the count register
  always_comb begin
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (int'(count_d) >= ALMOST_FULL_LEVEL);
    aempty_d = (int'(count_d) <= ALMOST_EMPTY_LEVEL);
    ovf_d    = bus.wr_req & ~w_en & ~bus.flush;
    unf_d    = bus.rd_req & ~r_en & ~bus.flush;
  end

  // Status register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= AE_RST;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Pointer/flag consistency: equal addresses mean full or empty by wrap bits
  assert property (@(posedge clk) disable iff (!rst_n)
    full_q == ((wr_addr == rd_addr) && (wr_wrap != rd_wrap)));
  assert property (@(posedge clk) disable iff (!rst_n)
    empty_q == ((wr_addr == rd_addr) && (wr_wrap == rd_wrap)));

  assign bus.w_en         = w_en;
  assign bus.r_en         = r_en;
  assign bus.w_addr       = wr_addr;
  assign bus.r_addr       = rd_addr;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl: three instances (depth 4, 5 and 8) share one
// request stream; a write/read tally model predicts every output.
module tb_fifo_ptr_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic wr_req = 1'b0;
  logic rd_req = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_ptr_ctrl_if #(.AW(2)) if4 ();
  fifo_ptr_ctrl_if #(.AW(3)) if5 ();
  fifo_ptr_ctrl_if #(.AW(3)) if8 ();

  assign if4.flush = flush;  assign if4.wr_req = wr_req;  assign if4.rd_req = rd_req;
  assign if5.flush = flush;  assign if5.wr_req = wr_req;  assign if5.rd_req = rd_req;
  assign if8.flush = flush;  assign if8.wr_req = wr_req;  assign if8.rd_req = rd_req;

  fifo_ptr_ctrl #(.MEMORY_DEPTH(4), .FIFO_ADDRESS_SIZE(2), .ALMOST_FULL_LEVEL(3), .ALMOST_EMPTY_LEVEL(1))
    u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  fifo_ptr_ctrl #(.MEMORY_DEPTH(5), .FIFO_ADDRESS_SIZE(3), .ALMOST_FULL_LEVEL(4), .ALMOST_EMPTY_LEVEL(1))
    u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));
  fifo_ptr_ctrl #(.MEMORY_DEPTH(8), .FIFO_ADDRESS_SIZE(3), .ALMOST_FULL_LEVEL(6), .ALMOST_EMPTY_LEVEL(2))
    u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  int dep[3] = '{4, 5, 8};
  int afl[3] = '{3, 4, 6};
  int ael[3] = '{1, 1, 2};

  // Model: totals of accepted writes/reads since the last clear
  int nw[3], nr[3];
  bit m_ovf[3], m_unf[3];
  bit e_wen[3], e_ren[3];
  int e_waddr[3], e_raddr[3];

  // Observed values
  logic        c_wen[3], c_ren[3];
  logic [31:0] c_waddr[3], c_raddr[3];
  logic [31:0] r_count[3], r_waddr[3], r_raddr[3];
  logic        r_full[3], r_empty[3], r_af[3], r_ae[3], r_ovf[3], r_unf[3];
  logic        r_wwrap[3], r_rwrap[3];

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      nw[i] = 0; nr[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    end
  endtask

  task automatic sample_comb();
    c_wen[0] = if4.w_en;  c_ren[0] = if4.r_en;  c_waddr[0] = 32'(if4.w_addr);  c_raddr[0] = 32'(if4.r_addr);
    c_wen[1] = if5.w_en;  c_ren[1] = if5.r_en;  c_waddr[1] = 32'(if5.w_addr);  c_raddr[1] = 32'(if5.r_addr);
    c_wen[2] = if8.w_en;  c_ren[2] = if8.r_en;  c_waddr[2] = 32'(if8.w_addr);  c_raddr[2] = 32'(if8.r_addr);
  endtask

  task automatic sample_regs();
    r_count[0] = 32'(if4.count); r_waddr[0] = 32'(if4.w_addr); r_raddr[0] = 32'(if4.r_addr);
    r_count[1] = 32'(if5.count); r_waddr[1] = 32'(if5.w_addr); r_raddr[1] = 32'(if5.r_addr);
    r_count[2] = 32'(if8.count); r_waddr[2] = 32'(if8.w_addr); r_raddr[2] = 32'(if8.r_addr);
    r_full[0] = if4.full; r_empty[0] = if4.empty; r_af[0] = if4.almost_full; r_ae[0] = if4.almost_empty;
    r_full[1] = if5.full; r_empty[1] = if5.empty; r_af[1] = if5.almost_full; r_ae[1] = if5.almost_empty;
    r_full[2] = if8.full; r_empty[2] = if8.empty; r_af[2] = if8.almost_full; r_ae[2] = if8.almost_empty;
    r_ovf[0] = if4.overflow; r_unf[0] = if4.underflow;
    r_ovf[1] = if5.overflow; r_unf[1] = if5.underflow;
    r_ovf[2] = if8.overflow; r_unf[2] = if8.underflow;
    r_wwrap[0] = u_dut4.wr_wrap; r_rwrap[0] = u_dut4.rd_wrap;
    r_wwrap[1] = u_dut5.wr_wrap; r_rwrap[1] = u_dut5.rd_wrap;
    r_wwrap[2] = u_dut8.wr_wrap; r_rwrap[2] = u_dut8.rd_wrap;
  endtask

  // One clock of stimulus: comb outputs sampled before the edge, registered
  // outputs sampled just after it, model advanced in between.
  task automatic drive_cycle(input bit wr, input bit rd, input bit fl);
    int cnt;
    @(negedge clk);
    wr_req = wr; rd_req = rd; flush = fl;
    #1;
    sample_comb();
    for (int i = 0; i < 3; i++) begin
      cnt = nw[i] - nr[i];
      e_wen[i]   = wr && (cnt < dep[i] || rd) && !fl;
      e_ren[i]   = rd && (cnt > 0) && !fl;
      e_waddr[i] = nw[i] % dep[i];
      e_raddr[i] = nr[i] % dep[i];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (fl) begin
        nw[i] = 0; nr[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
      end else begin
        if (e_wen[i]) nw[i]++;
        if (e_ren[i]) nr[i]++;
        m_ovf[i] = wr && !e_wen[i];
        m_unf[i] = rd && !e_ren[i];
      end
    end
    sample_regs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    sample_regs();
    model_clear();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({r_full[i], r_empty[i], r_af[i], r_ae[i], r_ovf[i], r_unf[i]} !== 6'b010100) begin
        failures++;
        $display("FAIL reset_flags dut%0d got=%b exp=010100", i,
                 {r_full[i], r_empty[i], r_af[i], r_ae[i], r_ovf[i], r_unf[i]});
      end
      checks++;
      if (r_count[i] !== 0 || r_waddr[i] !== 0 || r_raddr[i] !== 0) begin
        failures++;
        $display("FAIL reset_state dut%0d count=%0d waddr=%0d raddr=%0d exp=0", i, r_count[i], r_waddr[i], r_raddr[i]);
      end
    end
  endtask

  task automatic test_fill_overflow();
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1, 0, 0);
      checks++;
      if (c_waddr[0] !== 32'(k) || r_count[0] !== 32'(k + 1) || r_full[0] !== logic'(k == 3)) begin
        failures++;
        $display("FAIL fill_d4 step%0d waddr=%0d count=%0d full=%b exp %0d/%0d/%0d", k,
                 c_waddr[0], r_count[0], r_full[0], k, k + 1, (k == 3));
      end
    end
    drive_cycle(1, 0, 0);
    checks++;
    if (c_wen[0] !== 1'b0 || r_ovf[0] !== 1'b1) begin
      failures++;
      $display("FAIL overflow_d4 w_en=%b ovf=%b exp w_en=0 ovf=1", c_wen[0], r_ovf[0]);
    end
    drive_cycle(0, 0, 0);
    checks++;
    if (r_ovf[0] !== 1'b0 || r_count[0] !== 4) begin
      failures++;
      $display("FAIL overflow_pulse_d4 ovf=%b count=%0d exp ovf=0 count=4", r_ovf[0], r_count[0]);
    end
  endtask

  task automatic test_full_simul();
    drive_cycle(1, 1, 0);
    checks++;
    if ({c_wen[0], c_ren[0], r_full[0], r_ovf[0]} !== 4'b1110 || r_count[0] !== 4) begin
      failures++;
      $display("FAIL full_rw_d4 wen/ren/full/ovf=%b count=%0d exp 1110 count=4",
               {c_wen[0], c_ren[0], r_full[0], r_ovf[0]}, r_count[0]);
    end
  endtask

  task automatic test_flush();
    drive_cycle(0, 0, 1);
    for (int k = 0; k < 3; k++) drive_cycle(1, 0, 0);
    drive_cycle(1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({r_full[i], r_empty[i], r_af[i], r_ae[i], r_ovf[i], r_unf[i]} !== 6'b010100 ||
          r_count[i] !== 0 || r_waddr[i] !== 0 || r_raddr[i] !== 0) begin
        failures++;
        $display("FAIL flush dut%0d flags=%b count=%0d waddr=%0d raddr=%0d exp 010100/0/0/0", i,
                 {r_full[i], r_empty[i], r_af[i], r_ae[i], r_ovf[i], r_unf[i]}, r_count[i], r_waddr[i], r_raddr[i]);
      end
    end
  endtask

  task automatic test_empty_simul();
    drive_cycle(1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({c_wen[i], c_ren[i], r_unf[i], r_empty[i]} !== 4'b1010 || r_count[i] !== 1 || c_waddr[i] !== 0) begin
        failures++;
        $display("FAIL empty_rw dut%0d wen/ren/unf/empty=%b count=%0d waddr=%0d exp 1010/1/0", i,
                 {c_wen[i], c_ren[i], r_unf[i], r_empty[i]}, r_count[i], c_waddr[i]);
      end
    end
    drive_cycle(0, 0, 0);
    checks++;
    if (r_unf[0] !== 1'b0) begin
      failures++;
      $display("FAIL underflow_pulse got=%b exp=0", r_unf[0]);
    end
  endtask

  task automatic test_wrap5();
    drive_cycle(0, 0, 1);
    for (int k = 0; k < 12; k++) begin
      drive_cycle(1, (k != 0), 0);
      checks++;
      if (c_waddr[1] !== 32'(k % 5) || r_wwrap[1] !== logic'(((k + 1) / 5) % 2)) begin
        failures++;
        $display("FAIL wrap_d5 step%0d waddr=%0d wrap=%b exp %0d/%0d", k, c_waddr[1], r_wwrap[1],
                 k % 5, ((k + 1) / 5) % 2);
      end
    end
  endtask

  task automatic test_almost();
    drive_cycle(0, 0, 1);
    for (int k = 1; k <= 7; k++) begin
      drive_cycle(1, 0, 0);
      checks++;
      if (r_count[2] !== 32'(k) || r_af[2] !== logic'(k >= 6) || r_ae[2] !== logic'(k <= 2)) begin
        failures++;
        $display("FAIL almost_d8 count=%0d af=%b ae=%b exp %0d/%0d/%0d", r_count[2], r_af[2], r_ae[2],
                 k, (k >= 6), (k <= 2));
      end
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(0, 0, 1);
    drive_cycle(1, 0, 0);
    drive_cycle(1, 0, 0);
    @(negedge clk);
    wr_req = 1'b1; rd_req = 1'b0; flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sample_regs();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({r_full[i], r_empty[i], r_ovf[i]} !== 3'b010 || r_count[i] !== 0 || r_waddr[i] !== 0 || r_raddr[i] !== 0) begin
        failures++;
        $display("FAIL async_reset dut%0d full/empty/ovf=%b count=%0d waddr=%0d exp 010/0/0", i,
                 {r_full[i], r_empty[i], r_ovf[i]}, r_count[i], r_waddr[i]);
      end
    end
    wr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    drive_cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (c_waddr[i] !== 0 || c_wen[i] !== 1'b1 || r_count[i] !== 1) begin
        failures++;
        $display("FAIL post_reset_write dut%0d waddr=%0d wen=%b count=%0d exp 0/1/1", i, c_waddr[i], c_wen[i], r_count[i]);
      end
    end
  endtask

  task automatic test_random();
    int pw, pr, ec;
    bit wr, rd, fl;
    logic [7:0] exp_f;
    for (int n = 0; n < 600; n++) begin
      case ((n / 75) % 4)
        0: begin pw = 80; pr = 30; end
        1: begin pw = 30; pr = 80; end
        2: begin pw = 95; pr = 95; end
        default: begin pw = 50; pr = 50; end
      endcase
      wr = ($urandom_range(0, 99) < pw);
      rd = ($urandom_range(0, 99) < pr);
      fl = ($urandom_range(0, 79) == 0);
      drive_cycle(wr, rd, fl);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (c_wen[i] !== e_wen[i] || c_ren[i] !== e_ren[i]) begin
          failures++;
          $display("FAIL rnd_strobe n%0d dut%0d wen=%b ren=%b exp %b/%b", n, i, c_wen[i], c_ren[i], e_wen[i], e_ren[i]);
        end
        checks++;
        if (c_waddr[i] !== 32'(e_waddr[i]) || c_raddr[i] !== 32'(e_raddr[i])) begin
          failures++;
          $display("FAIL rnd_addr n%0d dut%0d waddr=%0d raddr=%0d exp %0d/%0d", n, i, c_waddr[i], c_raddr[i],
                   e_waddr[i], e_raddr[i]);
        end
        ec = nw[i] - nr[i];
        checks++;
        if (r_count[i] !== 32'(ec) || r_waddr[i] !== 32'(nw[i] % dep[i]) || r_raddr[i] !== 32'(nr[i] % dep[i])) begin
          failures++;
          $display("FAIL rnd_state n%0d dut%0d count=%0d waddr=%0d raddr=%0d exp %0d/%0d/%0d", n, i,
                   r_count[i], r_waddr[i], r_raddr[i], ec, nw[i] % dep[i], nr[i] % dep[i]);
        end
        exp_f = {ec == dep[i], ec == 0, ec >= afl[i], ec <= ael[i], m_ovf[i], m_unf[i],
                 ((nw[i] / dep[i]) % 2) == 1, ((nr[i] / dep[i]) % 2) == 1};
        checks++;
        if ({r_full[i], r_empty[i], r_af[i], r_ae[i], r_ovf[i], r_unf[i], r_wwrap[i], r_rwrap[i]} !== exp_f) begin
          failures++;
          $display("FAIL rnd_flags n%0d dut%0d full/empty/af/ae/ovf/unf/ww/rw=%b exp=%b", n, i,
                   {r_full[i], r_empty[i], r_af[i], r_ae[i], r_ovf[i], r_unf[i], r_wwrap[i], r_rwrap[i]}, exp_f);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    model_clear();
    test_reset();
    test_fill_overflow();
    test_full_simul();
    test_flush();
    test_empty_simul();
    test_wrap5();
    test_almost();
    test_async_reset();
    test_random();
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
